// File: rtl/alarm_controller.sv
// alarm_controller: arm/exit/entry/siren sequencer that drives the enable of the zone-OR alarm path.
module alarm_controller #(
  parameter logic [7:0] EXIT_TIME  = 8'd30,
  parameter logic [7:0] ENTRY_TIME = 8'd15,
  parameter logic [7:0] SIREN_TIME = 8'd120,
  parameter logic [3:0] ENTRY_MASK = 4'b0001
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic [3:0] sensor_i,
  input  logic       arm_i,
  input  logic       disarm_i,
  output logic       enable_o,
  output logic       siren_o,
  output logic [2:0] state_o,
  output logic [7:0] count_o,
  output logic [3:0] zone_latch_o,
  output logic       arm_fault_o
);
  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic [3:0] zone_q, zone_d;
  logic       fault_q, fault_d;
  logic       inst, del;

  assign inst = |(sensor_i & ~ENTRY_MASK);
  assign del  = |(sensor_i & ENTRY_MASK);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_DISARMED;
      count_q <= '0;
      zone_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      zone_q  <= zone_d;
      fault_q <= fault_d;
    end
  end

  // Disarm overrides everything; a reload on a transition swallows a coincident tick.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    zone_d  = zone_q;
    fault_d = 1'b0;
    if (disarm_i) begin
      state_d = S_DISARMED;
      count_d = '0;
    end else begin
      case (state_q)
        S_DISARMED: if (arm_i) begin
          if (sensor_i == 4'd0) begin
            state_d = S_EXIT;
            count_d = EXIT_TIME;
            zone_d  = '0;
          end else fault_d = 1'b1;
        end
        S_EXIT: if (tick_i && count_q != 8'd0) begin
          count_d = count_q - 8'd1;
          state_d = (count_q == 8'd1) ? S_ARMED : S_EXIT;
        end
        S_ARMED: if (inst || del) begin
          state_d = inst ? S_ALARM : S_ENTRY;
          count_d = inst ? SIREN_TIME : ENTRY_TIME;
          zone_d  = (zone_q == 4'd0) ? sensor_i : zone_q;
        end
        S_ENTRY: if (inst || (tick_i && count_q == 8'd1)) begin
          state_d = S_ALARM;
          count_d = SIREN_TIME;
        end else if (tick_i && count_q > 8'd1) count_d = count_q - 8'd1;
        S_ALARM: if (tick_i && count_q != 8'd0) begin
          count_d = count_q - 8'd1;
          state_d = (count_q == 8'd1) ? S_ARMED : S_ALARM;
        end
        default: begin
          state_d = S_DISARMED;
          count_d = '0;
        end
      endcase
    end
  end

  assign state_o      = state_q;
  assign count_o      = count_q;
  assign zone_latch_o = zone_q;
  assign arm_fault_o  = fault_q;
  assign enable_o     = (state_q == S_ARMED) || (state_q == S_ENTRY) || (state_q == S_ALARM);
  assign siren_o      = (state_q == S_ALARM);
endmodule
